// File: rtl/seq_detect_param.sv
// Serial-bit sequence detector with a runtime-loadable pattern and length.
// Supports overlapping and non-overlapping matching, an input-valid qualifier and a saturating match counter.
module seq_detect_param #(
    parameter int                MAXLEN  = 8,
    parameter int                CW      = 8,
    parameter logic [MAXLEN-1:0] PAT_RST = 8'b0000_0011,
    parameter int                LEN_RST = 4
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         x,
    input  logic                         x_vld,
    input  logic                         pat_ld,
    input  logic [MAXLEN-1:0]            pat_in,
    input  logic [$clog2(MAXLEN+1)-1:0]  len_in,
    input  logic                         overlap,
    output logic                         z,
    output logic [CW-1:0]                match_cnt
);

    localparam int             LW       = $clog2(MAXLEN + 1);
    localparam logic [LW-1:0]  MAXLEN_L = LW'(MAXLEN);
    localparam logic [LW-1:0]  LEN_RST_L = LW'(LEN_RST);

    logic [MAXLEN-1:0] r_hist;
    logic [LW-1:0]     r_fill;
    logic [MAXLEN-1:0] r_pat;
    logic [LW-1:0]     r_len;
    logic              r_z;
    logic [CW-1:0]     r_cnt;

    logic              w_accept;
    logic [MAXLEN-1:0] w_hist_nxt;
    logic [MAXLEN-1:0] w_mask;
    logic              w_fill_ok;
    logic              w_match;
    logic [LW-1:0]     w_len_clamp;
    logic [LW-1:0]     w_fill_inc;

    // A load strobe wins over a valid bit on the same edge, so that bit is dropped.
    assign w_accept   = x_vld & ~pat_ld;
    assign w_hist_nxt = {r_hist[MAXLEN-2:0], x};

    // NOTE: every bit gets a default before the loop so no latch is inferred.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAXLEN; i++) begin
            w_mask[i] = (LW'(i) < r_len);
        end
    end

    // The incoming bit counts towards the fill, hence the +1 against the stored value.
    assign w_fill_ok = ({1'b0, r_fill} + 1'b1) >= {1'b0, r_len};
    assign w_match   = w_accept & w_fill_ok & (((w_hist_nxt ^ r_pat) & w_mask) == '0);

    assign w_len_clamp = ((len_in == '0) || (len_in > MAXLEN_L)) ? MAXLEN_L : len_in;
    assign w_fill_inc  = (r_fill == MAXLEN_L) ? r_fill : r_fill + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_pat <= PAT_RST;
            r_len <= LEN_RST_L;
        end else if (pat_ld) begin
            r_pat <= pat_in;
            r_len <= w_len_clamp;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (pat_ld) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (x_vld) begin
            r_hist <= w_hist_nxt;
            // Non-overlap restarts the fill; the history keeps shifting regardless.
            r_fill <= (w_match && !overlap) ? '0 : w_fill_inc;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_z   <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_z <= w_match;
            if (w_match && !(&r_cnt)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign z         = r_z;
    assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: a queue-based reference model checked every cycle,
// plus directed scenarios pinned with hand-computed literals.
module tb_seq_detect_param;

    localparam int MAXLEN = 8;

    logic       clk;
    logic       clr;
    logic       x, x_vld, pat_ld, overlap;
    logic [7:0] pat_in;
    logic [3:0] len_in;
    logic       z;
    logic [7:0] match_cnt;

    logic       x2, v2, ld2, ov2;
    logic [7:0] pi2;
    logic [3:0] li2;
    logic       z2;
    logic [1:0] cnt2;

    seq_detect_param dut (
        .clk(clk), .clr(clr), .x(x), .x_vld(x_vld), .pat_ld(pat_ld),
        .pat_in(pat_in), .len_in(len_in), .overlap(overlap),
        .z(z), .match_cnt(match_cnt)
    );

    seq_detect_param #(.CW(2)) dut2 (
        .clk(clk), .clr(clr), .x(x2), .x_vld(v2), .pat_ld(ld2),
        .pat_in(pi2), .len_in(li2), .overlap(ov2),
        .z(z2), .match_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the accepted bits since the last restart, newest at the back.
    bit         m_q[$];
    logic [7:0] m_pat;
    int         m_len;
    int         m_cnt;
    bit         m_z;

    int n_vec;
    int n_mis;

    task automatic model_reset();
        m_q.delete();
        m_pat = 8'b0000_0011;
        m_len = 4;
        m_cnt = 0;
        m_z   = 1'b0;
    endtask

    task automatic model_step();
        bit hit;
        if (!clr) return;
        if (pat_ld) begin
            m_pat = pat_in;
            m_len = (len_in == 0 || len_in > MAXLEN) ? MAXLEN : int'(len_in);
            m_q.delete();
            m_z = 1'b0;
        end else if (x_vld) begin
            m_q.push_back(x);
            if (m_q.size() > MAXLEN) void'(m_q.pop_front());
            hit = (m_q.size() >= m_len);
            for (int k = 0; k < m_len; k++) begin
                if (hit && (m_q[m_q.size() - 1 - k] != m_pat[k])) hit = 1'b0;
            end
            m_z = hit;
            if (hit) begin
                if (m_cnt < 255) m_cnt++;
                if (!overlap) m_q.delete();
            end
        end else begin
            m_z = 1'b0;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l);
        pat_ld = 1'b1; x_vld = 1'b0; pat_in = p; len_in = l;
        tick();
        pat_ld = 1'b0;
    endtask

    // bits[i] is the i-th bit in time order; zmask[i] is z right after that bit's edge.
    task automatic stream(input logic [31:0] bits, input int n, output logic [31:0] zmask);
        zmask = '0;
        for (int i = 0; i < n; i++) begin
            x = bits[i]; x_vld = 1'b1; pat_ld = 1'b0;
            tick();
            zmask[i] = z;
        end
        x_vld = 1'b0;
    endtask

    initial begin
        logic [31:0] zm;
        int          c0;
        n_vec = 0; n_mis = 0;
        clr = 1'b0; x = 0; x_vld = 0; pat_ld = 0; overlap = 1; pat_in = '0; len_in = '0;
        x2 = 0; v2 = 0; ld2 = 0; ov2 = 1; pi2 = '0; li2 = '0;
        model_reset();
        #12 clr = 1'b1;
        check("reset_z", int'(z), 0);
        check("reset_cnt", int'(match_cnt), 0);

        fork
            forever begin
                @(negedge clk);
                n_vec++;
                if (z !== m_z || match_cnt !== 8'(m_cnt)) begin
                    n_mis++;
                    $display("FAIL model_cmp: z=%0b cnt=%0d expected z=%0b cnt=%0d at %0t",
                             z, match_cnt, m_z, m_cnt, $time);
                end
            end
        join_none

        @(posedge clk); #1;

        // Default pattern 0011, overlapping stream.
        overlap = 1'b1;
        stream(32'h66CC, 16, zm);
        check("t1_pulses", int'(zm), 32'h4088);
        check("t1_cnt", int'(match_cnt), 3);

        // Pattern 101, overlap then non-overlap.
        load(8'b101, 4'd3);
        c0 = int'(match_cnt);
        stream(32'h15, 5, zm);
        check("t2_ovl_pulses", int'(zm), 32'h14);
        check("t2_ovl_cnt", int'(match_cnt), c0 + 2);
        overlap = 1'b0;
        load(8'b101, 4'd3);
        stream(32'h15, 5, zm);
        check("t2_novl_pulses", int'(zm), 32'h04);
        check("t2_novl_cnt", int'(match_cnt), c0 + 3);
        overlap = 1'b1;

        // Valid bits 0,0,1,1 interleaved with idle cycles.
        load(8'b0011, 4'd4);
        zm = '0;
        for (int i = 0; i < 9; i++) begin
            x_vld = (i % 2 == 0) && (i < 8);
            x     = x_vld ? ((i >= 4) ? 1'b1 : 1'b0) : 1'($urandom_range(0, 1));
            tick();
            zm[i] = z;
        end
        x_vld = 1'b0;
        check("t3_pulses", int'(zm), 32'h40);

        // Load with a simultaneous valid bit drops that bit and restarts the fill.
        stream(32'h4, 3, zm);
        pat_ld = 1'b1; x_vld = 1'b1; x = 1'b1; pat_in = 8'b0011; len_in = 4'd4;
        tick();
        pat_ld = 1'b0; x_vld = 1'b0;
        check("t4_ld_z", int'(z), 0);
        stream(32'hC, 4, zm);
        check("t4_fresh_pulses", int'(zm), 32'h8);
        load(8'hA5, 4'd0);
        stream(32'hA5, 8, zm);
        check("t4_len0_pulses", int'(zm), 32'h80);

        // Narrow counter instance, single-bit pattern.
        ld2 = 1'b1; pi2 = 8'h01; li2 = 4'd1;
        tick();
        ld2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            x2 = 1'b1; v2 = 1'b1;
            tick();
            check("t5_z", int'(z2), 1);
            check("t5_cnt", int'(cnt2), (i < 3) ? i + 1 : 3);
        end
        v2 = 1'b0;
        tick();
        check("t5_idle_z", int'(z2), 0);
        check("t5_hold_cnt", int'(cnt2), 3);

        // Asynchronous reset in the middle of a match pulse.
        load(8'b0011, 4'd4);
        stream(32'hC, 4, zm);
        check("t6_pre_z", int'(z), 1);
        #2 clr = 1'b0;
        model_reset();
        #1;
        check("t6_async_z", int'(z), 0);
        check("t6_async_cnt", int'(match_cnt), 0);
        tick();
        clr = 1'b1;
        stream(32'h6, 3, zm);
        check("t6_three_bits", int'(zm), 0);
        stream(32'hC, 4, zm);
        check("t6_default_pat", int'(zm), 32'h8);

        // Counter saturation at 255.
        load(8'h01, 4'd1);
        for (int i = 0; i < 260; i++) begin
            x = 1'b1; x_vld = 1'b1;
            tick();
        end
        x_vld = 1'b0;
        check("sat_cnt", int'(match_cnt), 255);
        check("sat_z", int'(z), 1);

        // Randomised traffic against the model.
        clr = 1'b0;
        model_reset();
        #2 clr = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                pat_ld = 1'b1;
                pat_in = 8'($urandom);
                len_in = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 15));
            end else begin
                pat_ld = 1'b0;
            end
            x_vld = ($urandom_range(0, 99) < 80);
            x     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) overlap = 1'($urandom_range(0, 1));
            tick();
        end
        pat_ld = 1'b0; x_vld = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
